// File: rtl/spi_cmd_log.sv
// spi_cmd_log
//   Command-log FIFO placed after the SPI emulator's command decoder. Every
//   cmd_strobe is timestamped and queued, so firmware can drain commands at
//   its own pace instead of losing them to a single latched register.
//
// Ports
//   clk, resetn       system clock (rising edge), asynchronous active-low reset
//   cmd_strobe        one-cycle pulse: cmd_in/addr_in/len_in hold a new command
//   cmd_in[7:0]       SPI opcode
//   addr_in[31:0]     SPI address
//   len_in[11:0]      transfer length
//   iomem_sel         bus access to this block (valid AND address decode)
//   iomem_addr[3:0]   byte offset in the window, [3:2] selects the register
//   iomem_wstrb[3:0]  byte write strobes, all zero for a read
//   iomem_wdata[31:0] write data (contents unused: writes are pure triggers)
//   iomem_ready       one-cycle access-complete pulse
//   iomem_rdata[31:0] read data, valid while iomem_ready is high
//   irq               high while the FIFO holds at least one entry
//
// Register window
//   0x00 STATUS  {dropped[15:0], 5'b0, overflow, full, empty, count[7:0]}
//                write with wstrb[3] or wstrb[2] clears dropped and overflow
//   0x04 HEAD0   {ts (zero-extended to 24 bits), cmd}
//   0x08 HEAD1   addr
//   0x0C HEAD2   {20'b0, len}; any write pops the head entry
//   HEAD0..2 read as zero while the FIFO is empty.

module spi_cmd_log #(
    parameter int DEPTH_LOG2 = 5,
    parameter int TS_WIDTH   = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_strobe,
    input  logic [7:0]  cmd_in,
    input  logic [31:0] addr_in,
    input  logic [11:0] len_in,
    input  logic        iomem_sel,
    input  logic [3:0]  iomem_addr,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = DEPTH_LOG2;
    localparam int EW    = TS_WIDTH + 52;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_HEAD0  = 2'd1;
    localparam logic [1:0] REG_HEAD1  = 2'd2;
    localparam logic [1:0] REG_HEAD2  = 2'd3;

    logic [TS_WIDTH-1:0] ts_q;
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic [15:0]         dropped_q;
    logic [15:0]         dropped_d;
    logic                overflow_q;
    logic                overflow_d;
    logic                ready_q;
    logic [31:0]         rdata_q;
    logic [31:0]         rdata_d;
    logic                irq_q;

    logic [EW-1:0]       mem [DEPTH];

    logic                access;
    logic                pop_en;
    logic                push_en;
    logic                drop;
    logic                clear_req;
    logic                empty;
    logic                full;
    logic [EW-1:0]       head;
    logic [TS_WIDTH-1:0] head_ts;
    logic [7:0]          head_cmd;
    logic [31:0]         head_addr;
    logic [11:0]         head_len;

    // Only the register select and the strobes matter on the bus side.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{iomem_addr[1:0], iomem_wdata};

    // A bus access starts only when no ready pulse is in flight, which caps
    // the rate at one access per two cycles even if iomem_sel stays high.
    // A pop on an empty FIFO is silently ignored; a pop on a full FIFO frees
    // the slot that a same-cycle strobe then fills, so nothing is dropped.
    always_comb begin
        access    = iomem_sel & ~ready_q;
        empty     = (count_q == '0);
        full      = (count_q == FULL_COUNT);
        pop_en    = access & (|iomem_wstrb) & (iomem_addr[3:2] == REG_HEAD2) & ~empty;
        clear_req = access & (iomem_wstrb[3] | iomem_wstrb[2]) & (iomem_addr[3:2] == REG_STATUS);
        push_en   = cmd_strobe & (~full | pop_en);
        drop      = cmd_strobe & full & ~pop_en;
    end

    // Occupancy and drop statistics. The clear has priority over a drop that
    // lands on the same edge, so firmware never sees a stale nonzero count
    // right after acknowledging it.
    always_comb begin
        count_d = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CW'(1);
        end

        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        if (clear_req) begin
            dropped_d  = '0;
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    // Unpack the head entry; layout is {ts, cmd, addr, len}.
    always_comb begin
        head      = mem[rd_ptr_q];
        head_ts   = head[EW-1 -: TS_WIDTH];
        head_cmd  = head[51:44];
        head_addr = head[43:12];
        head_len  = head[11:0];
    end

    // Read mux, evaluated from pre-edge state.
    always_comb begin
        rdata_d = '0;
        case (iomem_addr[3:2])
            REG_STATUS: rdata_d = {dropped_q, 5'b0, overflow_q, full, empty, 8'(count_q)};
            REG_HEAD0:  if (!empty) rdata_d = {24'(head_ts), head_cmd};
            REG_HEAD1:  if (!empty) rdata_d = head_addr;
            REG_HEAD2:  if (!empty) rdata_d = {20'b0, head_len};
            default:    rdata_d = '0;
        endcase
    end

    // Control state; the irq is registered from the next-state occupancy so
    // it changes on the same edge as the count itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            ts_q       <= ts_q + TS_WIDTH'(1);
            if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
            ready_q    <= access;
            if (access) rdata_q <= rdata_d;
            irq_q      <= (count_d != '0);
        end
    end

    // Entry storage has no reset; only slots between the pointers are read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= {ts_q, cmd_in, addr_in, len_in};
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_spi_cmd_log.sv
// tb_spi_cmd_log
//   Drives spi_cmd_log with randomized commands and bus accesses and compares
//   every register read against a queue-based model of the command log.
//   A second instance with an 8-bit timestamp receives identical stimulus so
//   a timestamp wrap can be observed in a few hundred cycles.

module tb_spi_cmd_log;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_strobe = 1'b0;
    logic [7:0]  cmd_in = '0;
    logic [31:0] addr_in = '0;
    logic [11:0] len_in = '0;
    logic        iomem_sel = 1'b0;
    logic [3:0]  iomem_addr = '0;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_wdata = '0;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        irq;
    logic        iomem_ready_ts;
    logic [31:0] iomem_rdata_ts;
    logic        irq_ts;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    spi_cmd_log dut (
        .clk(clk), .resetn(resetn), .cmd_strobe(cmd_strobe), .cmd_in(cmd_in),
        .addr_in(addr_in), .len_in(len_in), .iomem_sel(iomem_sel),
        .iomem_addr(iomem_addr), .iomem_wstrb(iomem_wstrb), .iomem_wdata(iomem_wdata),
        .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata), .irq(irq)
    );

    spi_cmd_log #(.TS_WIDTH(8)) dutTs (
        .clk(clk), .resetn(resetn), .cmd_strobe(cmd_strobe), .cmd_in(cmd_in),
        .addr_in(addr_in), .len_in(len_in), .iomem_sel(iomem_sel),
        .iomem_addr(iomem_addr), .iomem_wstrb(iomem_wstrb), .iomem_wdata(iomem_wdata),
        .iomem_ready(iomem_ready_ts), .iomem_rdata(iomem_rdata_ts), .irq(irq_ts)
    );

    // Cycles elapsed since reset release: this is what a command's timestamp
    // should read when its strobe is sampled.
    int unsigned tbCycles;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) tbCycles <= 0;
        else         tbCycles <= tbCycles + 1;
    end

    // Reference model: queue of logged commands plus drop statistics.
    typedef struct {
        int unsigned cyc;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [11:0] len;
    } entry_t;

    entry_t      q[$];
    int unsigned droppedM = 0;
    bit          overflowM = 1'b0;

    function automatic logic [31:0] expReg(input int r, input int tsw);
        logic [15:0] d;
        logic [31:0] tsv;
        logic [31:0] res;
        int n;
        n   = q.size();
        res = '0;
        d   = (droppedM > 32'd65535) ? 16'hFFFF : droppedM[15:0];
        case (r)
            0: res = {d, 5'b0, overflowM, (n == DEPTH), (n == 0), n[7:0]};
            1: if (n != 0) begin
                   tsv = q[0].cyc & ((32'd1 << tsw) - 32'd1);
                   res = {tsv[23:0], q[0].cmd};
               end
            2: if (n != 0) res = q[0].addr;
            3: if (n != 0) res = {20'b0, q[0].len};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic void modelStrobe(input logic [7:0] c, input logic [31:0] a,
                                        input logic [11:0] l, input bit popNow);
        entry_t e;
        if (popNow && q.size() > 0) void'(q.pop_front());
        if (q.size() < DEPTH) begin
            e.cyc = tbCycles; e.cmd = c; e.addr = a; e.len = l;
            q.push_back(e);
        end else begin
            droppedM++;
            overflowM = 1'b1;
        end
    endfunction

    task automatic pushCmd(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
        @(negedge clk);
        cmd_strobe = 1'b1; cmd_in = c; addr_in = a; len_in = l;
        modelStrobe(c, a, l, 1'b0);
        @(posedge clk); #1;
        cmd_strobe = 1'b0;
    endtask

    // One complete bus access, optionally with a command strobe on the same edge.
    task automatic busAccess(input logic [3:0] a, input logic [3:0] ws, input bit doPush,
                             input logic [7:0] c, input logic [31:0] ad, input logic [11:0] l,
                             output logic [31:0] rd, output logic [31:0] rdTs);
        bit popNow;
        popNow = (ws != 4'h0) && (a[3:2] == 2'd3);
        @(negedge clk);
        iomem_sel = 1'b1; iomem_addr = a; iomem_wstrb = ws; iomem_wdata = $urandom;
        if (doPush) begin
            cmd_strobe = 1'b1; cmd_in = c; addr_in = ad; len_in = l;
            modelStrobe(c, ad, l, popNow);
        end else if (popNow && q.size() > 0) begin
            void'(q.pop_front());
        end
        if (a[3:2] == 2'd0 && (ws[3] || ws[2])) begin
            droppedM = 0; overflowM = 1'b0;
        end
        @(posedge clk); #1;
        cmd_strobe = 1'b0;
        checks++;
        if (iomem_ready !== 1'b1 || iomem_ready_ts !== 1'b1)
            $display("[TB] FAIL bus_ready: got %b/%b, want 1", iomem_ready, iomem_ready_ts);
        else passes++;
        rd = iomem_rdata; rdTs = iomem_rdata_ts;
        iomem_sel = 1'b0; iomem_wstrb = 4'h0;
        @(posedge clk); #1;
        checks++;
        if (iomem_ready !== 1'b0)
            $display("[TB] FAIL bus_ready_drop: got %b, want 0", iomem_ready);
        else passes++;
    endtask

    task automatic readReg(input int r, output logic [31:0] rd, output logic [31:0] rdTs);
        busAccess(4'(r * 4), 4'h0, 1'b0, 8'h0, 32'h0, 12'h0, rd, rdTs);
    endtask

    task automatic popHead();
        logic [31:0] rd, rdTs;
        busAccess(4'hC, 4'($urandom_range(1, 15)), 1'b0, 8'h0, 32'h0, 12'h0, rd, rdTs);
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0; cmd_strobe = 1'b0; iomem_sel = 1'b0; iomem_wstrb = 4'h0;
        q.delete(); droppedM = 0; overflowM = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd, rdTs;
        logic [31:0] expVals [4];
        expVals[0] = 32'h0000_0100; expVals[1] = 32'h0; expVals[2] = 32'h0; expVals[3] = 32'h0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0 || iomem_ready !== 1'b0 || iomem_rdata !== 32'h0)
            $display("[TB] FAIL reset_outputs: got irq=%b ready=%b rdata=%h, want 0/0/0",
                     irq, iomem_ready, iomem_rdata);
        else passes++;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) pushCmd(8'($urandom), $urandom, 12'($urandom));
        @(negedge clk);
        resetn = 1'b0;
        q.delete(); droppedM = 0; overflowM = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b, want 0", irq);
        else passes++;
        for (int r = 0; r < 4; r++) begin
            readReg(r, rd, rdTs);
            checks++;
            if (rd !== expVals[r])
                $display("[TB] FAIL reset_reg%0d: got %h, want %h", r, rd, expVals[r]);
            else passes++;
        end
    endtask

    task automatic test_single_push();
        logic [31:0] rd, rdTs;
        logic [31:0] expVals [4];
        expVals[0] = 32'h0000_0001; expVals[1] = 32'h0000_100B;
        expVals[2] = 32'h0012_3456; expVals[3] = 32'h0000_0040;
        doReset();
        while (tbCycles < 15) @(negedge clk);
        pushCmd(8'h0B, 32'h0012_3456, 12'h040);
        checks++;
        if (irq !== 1'b1) $display("[TB] FAIL single_irq_set: got %b, want 1", irq);
        else passes++;
        for (int r = 0; r < 4; r++) begin
            readReg(r, rd, rdTs);
            checks++;
            if (rd !== expVals[r] || rd !== expReg(r, 24))
                $display("[TB] FAIL single_reg%0d: got %h, want %h", r, rd, expVals[r]);
            else passes++;
        end
        popHead();
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL single_irq_clear: got %b, want 0", irq);
        else passes++;
        readReg(0, rd, rdTs);
        checks++;
        if (rd !== 32'h0000_0100)
            $display("[TB] FAIL single_status_after_pop: got %h, want 00000100", rd);
        else passes++;
    endtask

    task automatic test_fill_drop();
        logic [31:0] rd, rdTs;
        doReset();
        for (int i = 0; i < 34; i++) pushCmd(8'($urandom), $urandom, 12'($urandom));
        checks++;
        if (irq !== 1'b1) $display("[TB] FAIL fill_irq: got %b, want 1", irq);
        else passes++;
        readReg(0, rd, rdTs);
        checks++;
        if (rd !== 32'h0002_0620 || rd !== expReg(0, 24))
            $display("[TB] FAIL fill_status: got %h, want 00020620", rd);
        else passes++;
        for (int r = 1; r < 4; r++) begin
            readReg(r, rd, rdTs);
            checks++;
            if (rd !== expReg(r, 24))
                $display("[TB] FAIL fill_head%0d: got %h, want %h", r, rd, expReg(r, 24));
            else passes++;
        end
        busAccess(4'h0, 4'b1100, 1'b0, 8'h0, 32'h0, 12'h0, rd, rdTs);
        readReg(0, rd, rdTs);
        checks++;
        if (rd !== 32'h0000_0220)
            $display("[TB] FAIL fill_clear: got %h, want 00000220", rd);
        else passes++;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd, rdTs;
        logic [31:0] newAddr;
        newAddr = $urandom;
        busAccess(4'hC, 4'($urandom_range(1, 15)), 1'b1, 8'hA5, newAddr, 12'($urandom), rd, rdTs);
        readReg(0, rd, rdTs);
        checks++;
        if (rd !== 32'h0000_0220)
            $display("[TB] FAIL full_pushpop_status: got %h, want 00000220", rd);
        else passes++;
        for (int i = 0; i < DEPTH; i++) begin
            for (int r = 1; r < 4; r++) begin
                readReg(r, rd, rdTs);
                checks++;
                if (rd !== expReg(r, 24))
                    $display("[TB] FAIL full_drain%0d_head%0d: got %h, want %h",
                             i, r, rd, expReg(r, 24));
                else passes++;
                if (i == DEPTH - 1 && r == 2) begin
                    checks++;
                    if (rd !== newAddr)
                        $display("[TB] FAIL full_tail_entry: got %h, want %h", rd, newAddr);
                    else passes++;
                end
            end
            popHead();
        end
        checks++;
        if (irq !== 1'b0) $display("[TB] FAIL full_drained_irq: got %b, want 0", irq);
        else passes++;
    endtask

    task automatic test_wrap_order();
        logic [31:0] rd, rdTs;
        int nextCmd = 0;
        int pushed = 0;
        doReset();
        while (pushed < 100 || q.size() > 0) begin
            if (q.size() > 0 && (pushed >= 100 || q.size() > 20 || $urandom_range(0, 1) == 1)) begin
                readReg(1, rd, rdTs);
                checks++;
                if (rd[7:0] !== 8'(nextCmd) || rd !== expReg(1, 24))
                    $display("[TB] FAIL order_head0: got %h, want cmd %h (%h)",
                             rd, 8'(nextCmd), expReg(1, 24));
                else passes++;
                nextCmd++;
                if (pushed < 100 && $urandom_range(0, 1) == 1) begin
                    busAccess(4'hC, 4'($urandom_range(1, 15)), 1'b1, 8'(pushed), $urandom,
                              12'($urandom), rd, rdTs);
                    pushed++;
                end else begin
                    popHead();
                end
            end else begin
                pushCmd(8'(pushed), $urandom, 12'($urandom));
                pushed++;
            end
            checks++;
            if (irq !== (q.size() != 0))
                $display("[TB] FAIL order_irq: got %b, want %b", irq, q.size() != 0);
            else passes++;
        end
        checks++;
        if (nextCmd != 100) $display("[TB] FAIL order_count: got %0d, want 100", nextCmd);
        else passes++;
    endtask

    task automatic test_ts_wrap();
        logic [31:0] rd, rdTs;
        logic [7:0] c0, c1;
        c0 = 8'($urandom); c1 = 8'($urandom);
        doReset();
        while (tbCycles < 253) @(negedge clk);
        pushCmd(c0, $urandom, 12'($urandom));
        repeat (2) @(negedge clk);
        pushCmd(c1, $urandom, 12'($urandom));
        readReg(1, rd, rdTs);
        checks++;
        if (rdTs !== {16'h0, 8'hFE, c0} || rd !== {16'h0, 8'hFE, c0})
            $display("[TB] FAIL ts_before_wrap: got %h/%h, want %h", rdTs, rd, {16'h0, 8'hFE, c0});
        else passes++;
        popHead();
        readReg(1, rd, rdTs);
        checks++;
        if (rdTs !== {16'h0, 8'h01, c1} || rdTs !== expReg(1, 8))
            $display("[TB] FAIL ts_after_wrap: got %h, want %h", rdTs, {16'h0, 8'h01, c1});
        else passes++;
        checks++;
        if (rd !== {16'h01, 8'h01, c1} || rd !== expReg(1, 24))
            $display("[TB] FAIL ts_wide_no_wrap: got %h, want %h", rd, {16'h01, 8'h01, c1});
        else passes++;
    endtask

    task automatic test_empty_pop_b2b();
        logic [31:0] rd, rdTs;
        int pulses = 0;
        doReset();
        popHead();
        readReg(0, rd, rdTs);
        checks++;
        if (rd !== 32'h0000_0100 || irq !== 1'b0)
            $display("[TB] FAIL empty_pop: got status=%h irq=%b, want 00000100/0", rd, irq);
        else passes++;
        @(negedge clk);
        iomem_sel = 1'b1; iomem_addr = 4'h0; iomem_wstrb = 4'h0;
        repeat (4) begin
            @(posedge clk); #1;
            if (iomem_ready === 1'b1) pulses++;
        end
        @(negedge clk);
        iomem_sel = 1'b0;
        checks++;
        if (pulses != 2) $display("[TB] FAIL b2b_ready_pulses: got %0d, want 2", pulses);
        else passes++;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_push();
        test_fill_drop();
        test_full_push_pop();
        test_wrap_order();
        test_ts_wrap();
        test_empty_pop_b2b();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
